// File: rtl/sc_data_bus_responder.sv
// Data-bus responder for the single-cycle core: word RAM plus MMIO block.
// Combinational reads; byte-lane writes, status and error pulse on the clock edge.
module sc_data_bus_responder #(
    parameter int          WIDTH     = 32,
    parameter int          MEM_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE = 32'h1000_0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bus_mem_read,
    input  logic             bus_mem_write,
    input  logic [WIDTH-1:0] bus_addr_in,
    input  logic [WIDTH-1:0] bus_data_in,
    input  logic [3:0]       bus_byteen,
    output logic [WIDTH-1:0] bus_data_out,
    output logic             bus_err,
    output logic             tohost_valid,
    output logic [WIDTH-1:0] tohost_data
);

    localparam int         AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [31:0] RAM_BYTES = 32'(MEM_WORDS * 4);

    localparam logic [1:0] REG_CYCLE   = 2'd0;
    localparam logic [1:0] REG_SCRATCH = 2'd1;
    localparam logic [1:0] REG_TOHOST  = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    logic [WIDTH-1:0] mem [MEM_WORDS];

    logic [WIDTH-1:0] cycle_q;
    logic [WIDTH-1:0] scratch_q;
    logic [15:0]      err_count;
    logic             err_q;

    logic             access;
    logic             hit_ram;
    logic             hit_mmio;
    logic [1:0]       reg_sel;
    logic [AW-1:0]    word_idx;
    logic [WIDTH-1:0] lane_mask;
    logic             wr_ok;
    logic             tohost_bad;
    logic             err_now;
    logic             ram_we;
    logic             scratch_we;
    logic             tohost_we;
    logic [WIDTH-1:0] status_word;

    assign access   = bus_mem_read | bus_mem_write;
    assign hit_ram  = bus_addr_in < RAM_BYTES;
    assign hit_mmio = !hit_ram && (bus_addr_in[31:4] == MMIO_BASE[31:4]);
    assign reg_sel  = bus_addr_in[3:2];
    assign word_idx = bus_addr_in[AW+1:2];

    assign lane_mask = {{8{bus_byteen[3]}}, {8{bus_byteen[2]}},
                        {8{bus_byteen[1]}}, {8{bus_byteen[0]}}};

    // A write only proceeds when it is not colliding with a read strobe.
    assign wr_ok = bus_mem_write & ~bus_mem_read;

    assign tohost_bad = wr_ok & hit_mmio & (reg_sel == REG_TOHOST)
                      & (bus_byteen != 4'b1111);

    assign err_now = (access & ~hit_ram & ~hit_mmio)
                   | (bus_mem_read & bus_mem_write)
                   | tohost_bad;

    assign ram_we     = wr_ok & hit_ram;
    assign scratch_we = wr_ok & hit_mmio & (reg_sel == REG_SCRATCH);
    assign tohost_we  = wr_ok & hit_mmio & (reg_sel == REG_TOHOST)
                      & (bus_byteen == 4'b1111) & ~tohost_valid;

    assign status_word = {err_count, 15'b0, tohost_valid};

    assign bus_err = err_q;

    // Combinational read mux; sees pre-write state of the current cycle.
    always_comb begin
        bus_data_out = '0;
        if (bus_mem_read) begin
            if (hit_ram) begin
                bus_data_out = mem[word_idx];
            end else if (hit_mmio) begin
                case (reg_sel)
                    REG_CYCLE:   bus_data_out = cycle_q;
                    REG_SCRATCH: bus_data_out = scratch_q;
                    REG_TOHOST:  bus_data_out = tohost_data;
                    REG_STATUS:  bus_data_out = status_word;
                endcase
            end
        end
    end

    // RAM byte-lane write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (rst_n && ram_we) begin
            mem[word_idx] <= (mem[word_idx] & ~lane_mask)
                           | (bus_data_in & lane_mask);
        end
    end

    // MMIO registers, error pulse and saturating error counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_q      <= '0;
            scratch_q    <= '0;
            tohost_valid <= 1'b0;
            tohost_data  <= '0;
            err_count    <= '0;
            err_q        <= 1'b0;
        end else begin
            cycle_q <= cycle_q + 1'b1;
            err_q   <= err_now;
            if (err_now && (err_count != 16'hFFFF)) begin
                err_count <= err_count + 16'd1;
            end
            if (scratch_we) begin
                scratch_q <= (scratch_q & ~lane_mask)
                           | (bus_data_in & lane_mask);
            end
            if (tohost_we) begin
                tohost_valid <= 1'b1;
                tohost_data  <= bus_data_in;
            end
        end
    end

endmodule

// File: tb/tb_sc_data_bus_responder.sv
// Self-checking bench for sc_data_bus_responder.
// Directed scenarios plus randomized traffic against a behavioural model.
module tb_sc_data_bus_responder;

    localparam logic [31:0] MMIO    = 32'h1000_0000;
    localparam logic [31:0] A_CYC   = MMIO + 32'h0;
    localparam logic [31:0] A_SCR   = MMIO + 32'h4;
    localparam logic [31:0] A_TH    = MMIO + 32'h8;
    localparam logic [31:0] A_STAT  = MMIO + 32'hC;

    logic        clk;
    logic        rst_n;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] dout;
    logic        err;
    logic        thv;
    logic [31:0] thd;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model state
    logic [31:0] ram_m [int];
    logic [31:0] cyc_m;
    logic [31:0] scr_m;
    logic        thv_m;
    logic [31:0] thd_m;
    logic [15:0] errc_m;
    logic        err_exp;

    sc_data_bus_responder dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus_mem_read  (rd),
        .bus_mem_write (wr),
        .bus_addr_in   (addr),
        .bus_data_in   (wdata),
        .bus_byteen    (be),
        .bus_data_out  (dout),
        .bus_err       (err),
        .tohost_valid  (thv),
        .tohost_data   (thd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] d,
                                          input logic [3:0]  lanes);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (lanes[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] exp_read();
        logic [31:0] r;
        r = 32'h0;
        if (rd) begin
            if (addr < 32'd4096) begin
                if (ram_m.exists(int'(addr >> 2))) r = ram_m[int'(addr >> 2)];
            end else if ((addr >> 4) == (MMIO >> 4)) begin
                case ((addr >> 2) & 32'd3)
                    32'd0:   r = cyc_m;
                    32'd1:   r = scr_m;
                    32'd2:   r = thd_m;
                    default: r = {errc_m, 15'b0, thv_m};
                endcase
            end
        end
        return r;
    endfunction

    task automatic drive(input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] lanes);
        rd = r; wr = w; addr = a; wdata = d; be = lanes;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    // Applies the model's view of one clock edge, then advances past it.
    task automatic tick();
        logic        is_ram;
        logic        is_mmio;
        logic [31:0] off;
        logic        e;
        if (!rst_n) begin
            cyc_m = 0; scr_m = 0; thv_m = 0; thd_m = 0;
            errc_m = 0; err_exp = 0;
        end else begin
            is_ram  = addr < 32'd4096;
            is_mmio = !is_ram && ((addr >> 4) == (MMIO >> 4));
            off     = (addr >> 2) & 32'd3;
            e       = 1'b0;
            if ((rd || wr) && !is_ram && !is_mmio) e = 1'b1;
            if (rd && wr) e = 1'b1;
            if (wr && !rd) begin
                if (is_ram) begin
                    if (ram_m.exists(int'(addr >> 2)))
                        ram_m[int'(addr >> 2)] = merge(ram_m[int'(addr >> 2)], wdata, be);
                    else
                        ram_m[int'(addr >> 2)] = merge(32'h0, wdata, be);
                end else if (is_mmio && off == 32'd1) begin
                    scr_m = merge(scr_m, wdata, be);
                end else if (is_mmio && off == 32'd2) begin
                    if (be != 4'hF) e = 1'b1;
                    else if (!thv_m) begin thv_m = 1'b1; thd_m = wdata; end
                end
            end
            if (e && errc_m != 16'hFFFF) errc_m = errc_m + 16'd1;
            err_exp = e;
            cyc_m = cyc_m + 32'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        repeat (3) tick();
        n_checks++;
        if (err !== 1'b0 || thv !== 1'b0 || thd !== 32'h0)
            $display("FAIL reset_outputs err=%b thv=%b thd=%h want 0 0 0", err, thv, thd);
        else n_pass++;
        drive(1'b1, 1'b0, A_STAT, 32'h0, 4'h0);
        #1;
        n_checks++;
        if (dout !== 32'h0) $display("FAIL reset_status got=%h want=0", dout);
        else n_pass++;
    endtask

    task automatic test_cycle();
        rst_n = 1'b1;
        drive(1'b1, 1'b0, A_CYC, 32'h0, 4'h0);
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++;
            if (dout !== 32'(i)) $display("FAIL cycle_seq[%0d] got=%0d want=%0d", i, dout, i);
            else n_pass++;
            tick();
        end
        drive(1'b0, 1'b1, A_CYC, 32'hDEAD_0000, 4'hF);
        tick();
        drive(1'b1, 1'b0, A_CYC, 32'h0, 4'h0);
        #1;
        n_checks++;
        if (dout !== cyc_m || err !== 1'b0)
            $display("FAIL cycle_write_ignored got=%h err=%b want=%h err=0", dout, err, cyc_m);
        else n_pass++;
        tick();
    endtask

    task automatic test_ram_lanes();
        drive(1'b0, 1'b1, 32'h10, 32'hAABB_CCDD, 4'b1111);
        tick();
        drive(1'b0, 1'b1, 32'h10, 32'h1122_3344, 4'b0101);
        tick();
        drive(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        #1;
        n_checks++;
        if (dout !== 32'hAA22_CC44 || err !== 1'b0)
            $display("FAIL ram_lanes got=%h err=%b want=aa22cc44 err=0", dout, err);
        else n_pass++;
        tick();
    endtask

    task automatic test_tohost();
        drive(1'b0, 1'b1, A_TH, 32'h1, 4'b0011);
        tick();
        n_checks++;
        if (err !== 1'b1 || thv !== 1'b0)
            $display("FAIL tohost_partial err=%b thv=%b want err=1 thv=0", err, thv);
        else n_pass++;
        drive(1'b1, 1'b0, A_STAT, 32'h0, 4'h0);
        #1;
        n_checks++;
        if (dout !== 32'h0001_0000) $display("FAIL tohost_status got=%h want=00010000", dout);
        else n_pass++;
        tick();
        drive(1'b0, 1'b1, A_TH, 32'h1, 4'hF);
        tick();
        n_checks++;
        if (thv !== 1'b1 || thd !== 32'h1 || err !== 1'b0)
            $display("FAIL tohost_first thv=%b thd=%h err=%b want 1 1 0", thv, thd, err);
        else n_pass++;
        drive(1'b0, 1'b1, A_TH, 32'h3, 4'hF);
        tick();
        n_checks++;
        if (thv !== 1'b1 || thd !== 32'h1 || err !== 1'b0)
            $display("FAIL tohost_sticky thv=%b thd=%h err=%b want 1 1 0", thv, thd, err);
        else n_pass++;
    endtask

    task automatic test_read_during_write();
        drive(1'b0, 1'b1, 32'h20, 32'h5, 4'hF);
        tick();
        drive(1'b0, 1'b1, 32'h20, 32'h9, 4'hF);
        #1;
        n_checks++;
        if (dout !== 32'h0) $display("FAIL rdw_read_low got=%h want=0", dout);
        else n_pass++;
        tick();
        drive(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
        #1;
        n_checks++;
        if (dout !== 32'h9) $display("FAIL rdw_after got=%h want=9", dout);
        else n_pass++;
        tick();
        drive(1'b0, 1'b1, 32'h0, 32'h0BAD_F00D, 4'hF);
        tick();
        drive(1'b1, 1'b1, 32'h0, 32'h1234_5678, 4'hF);
        #1;
        n_checks++;
        if (dout !== 32'h0BAD_F00D) $display("FAIL rw_collide_read got=%h want=0badf00d", dout);
        else n_pass++;
        tick();
        n_checks++;
        if (err !== 1'b1) $display("FAIL rw_collide_err got=%b want=1", err);
        else n_pass++;
        drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        n_checks++;
        if (dout !== 32'h0BAD_F00D) $display("FAIL rw_collide_ram got=%h want=0badf00d", dout);
        else n_pass++;
        tick();
    endtask

    task automatic test_unmapped();
        drive(1'b1, 1'b0, 32'h8000_0000, 32'h0, 4'h0);
        #1;
        n_checks++;
        if (dout !== 32'h0) $display("FAIL unmapped_data got=%h want=0", dout);
        else n_pass++;
        tick();
        n_checks++;
        if (err !== 1'b1) $display("FAIL unmapped_err got=%b want=1", err);
        else n_pass++;
        idle();
        tick();
        n_checks++;
        if (err !== 1'b0) $display("FAIL unmapped_err_once got=%b want=0", err);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] a;
        int          kind;
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, 1'b1, 32'h100 + 32'(4 * k), $urandom, 4'hF);
            tick();
        end
        for (int i = 0; i < 300; i++) begin
            kind = int'($urandom_range(0, 5));
            case (kind)
                0, 1:    a = 32'h100 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
                2:       a = MMIO + 32'(4 * $urandom_range(0, 3));
                3:       a = A_SCR;
                4:       a = 32'h2000_0000 + 32'($urandom_range(0, 255));
                default: a = 32'h100 + 32'(4 * $urandom_range(0, 7));
            endcase
            drive(($urandom_range(0, 3) == 0) ? 1'b1 : 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
            #1;
            n_checks++;
            if (dout !== exp_read())
                $display("FAIL rand_read[%0d] a=%h got=%h want=%h", i, a, dout, exp_read());
            else n_pass++;
            tick();
            n_checks++;
            if (err !== err_exp)
                $display("FAIL rand_err[%0d] a=%h got=%b want=%b", i, a, err, err_exp);
            else n_pass++;
        end
        idle();
        tick();
    endtask

    task automatic test_saturation();
        drive(1'b1, 1'b0, 32'h8000_0000, 32'h0, 4'h0);
        repeat (65540) tick();
        drive(1'b1, 1'b0, A_STAT, 32'h0, 4'h0);
        #1;
        n_checks++;
        if (dout[31:16] !== 16'hFFFF || dout[31:16] !== errc_m)
            $display("FAIL err_saturate got=%h want=ffff", dout[31:16]);
        else n_pass++;
        drive(1'b1, 1'b1, 32'h0, 32'h0, 4'hF);
        tick();
        drive(1'b1, 1'b0, A_STAT, 32'h0, 4'h0);
        #1;
        n_checks++;
        if (dout[31:16] !== 16'hFFFF || err !== 1'b1)
            $display("FAIL err_saturate_hold cnt=%h err=%b want=ffff 1", dout[31:16], err);
        else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 1'b1, A_SCR, 32'h1234, 4'hF);
        tick();
        drive(1'b1, 1'b0, A_SCR, 32'h0, 4'h0);
        #1;
        n_checks++;
        if (dout !== 32'h1234) $display("FAIL scratch_set got=%h want=1234", dout);
        else n_pass++;
        drive(1'b0, 1'b1, A_SCR, 32'hFFFF, 4'hF);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        drive(1'b1, 1'b0, A_SCR, 32'h0, 4'h0);
        #1;
        n_checks++;
        if (dout !== 32'h0 || thv !== 1'b0 || err !== 1'b0)
            $display("FAIL reset_mid_scratch got=%h thv=%b err=%b want 0 0 0", dout, thv, err);
        else n_pass++;
        drive(1'b1, 1'b0, A_STAT, 32'h0, 4'h0);
        #1;
        n_checks++;
        if (dout !== 32'h0) $display("FAIL reset_mid_status got=%h want=0", dout);
        else n_pass++;
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        test_reset();
        test_cycle();
        test_ram_lanes();
        test_tohost();
        test_read_during_write();
        test_unmapped();
        test_random();
        test_saturation();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
